cacheline_arbiter: RTL and testbench
====================================

# cacheline_arbiter

Two-requester arbiter sharing one physical-memory cacheline port between the instruction cache and the data cache of the pipelined rv32i core. It sits below both L1 caches and above the lower memory level, and sequences one full line transaction at a time. Simultaneous requests are granted round-robin. Outbound address, data and command are registered at grant so the lower level sees stable values for the whole transaction.

## Interface
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, line address width (line-aligned; low 5 bits passed through unchanged)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  read command to lower level
- pmem_write  out  1  write command to lower level
- pmem_addr  out  ADDR_W  registered transaction address
- pmem_wdata  out  LINE_W  registered writeback line
- pmem_rdata  in  LINE_W  line from lower level, valid with pmem_resp
- pmem_resp  in  1  lower-level completion pulse

## Operation
- States: IDLE, BUSY_I, BUSY_D. Register last_grant (I or D).
- IDLE:
  - only I requesting -> BUSY_I
  - only D (d_read|d_write) requesting -> BUSY_D
  - both requesting -> grant the side that is not last_grant
  - none -> stay
- On the grant edge:
  - latch addr into pmem_addr_q; latch d_wdata into pmem_wdata_q (D grants only)
  - latch command: I grant -> read; D grant -> write if d_write, else read
  - d_read and d_write both high -> treated as write
  - set last_grant to the granted side
- BUSY_x:
  - pmem_read or pmem_write held from the latched command; pmem_addr/pmem_wdata from registers
  - inputs from requesters are ignored (no re-sampling)
  - On pmem_resp=1:
    - x_resp=1 the same cycle (combinational)
    - x_rdata=pmem_rdata (combinational pass-through; i_rdata and d_rdata both always driven from pmem_rdata)
    - next state IDLE
- The other requester's resp is 0 at all times during the transaction.
- pmem_resp in IDLE: ignored; no resp emitted.
- Requester dropping its request mid-transaction: transaction still completes and the resp pulse is still issued.
- Reset (async assert, any state including mid-transaction):
  - state IDLE; last_grant=I, so D wins the first tie
  - pmem_read=0, pmem_write=0, pmem_addr=0, pmem_wdata=0
  - i_resp=0, d_resp=0
  - An in-flight lower-level transaction is abandoned.

## Timing
- Request sampled at edge N -> pmem command visible from cycle N+1.
- pmem_resp at cycle M -> x_resp at cycle M. Command deasserted from M+1 (IDLE).
- Minimum requester latency: request at cycle 0, pmem_resp at cycle 1, x_resp at cycle 1.
- Back-to-back: the earliest next command is cycle M+2 (one IDLE cycle between transactions). The requester's next request is sampled in IDLE at M+1.
- pmem_read/pmem_write never both high. Never high in IDLE.
- Starvation bound: with both sides continuously requesting, grants strictly alternate.

## Test plan
- Reset, then D-only read, addr 0x0000_1000, pmem_resp after 3 cycles with rdata=0xA5…A5:
  - pmem_read high cycles 1–3, pmem_addr=0x1000
  - d_resp=1 in cycle 3 only, d_rdata=0xA5…A5; i_resp stays 0
- Both i_read (0x40) and d_write (0x80, wdata=0x1234…) first sampled together after reset:
  - D granted first (pmem_write, addr 0x80); I granted next (pmem_read, addr 0x40)
  - exactly one IDLE cycle between the two commands
- Both sides held requesting for 6 transactions -> grant order D,I,D,I,D,I; pmem_read/pmem_write never both high.
- During BUSY_I, change i_addr from 0x100 to 0x200 and assert d_read:
  - pmem_addr stays 0x100 until resp
  - D granted after I completes
- Assert rst low mid-BUSY_D:
  - all outputs 0 immediately (async), state IDLE
  - after release, a subsequent tie grants D
- pmem_resp pulse while IDLE with no requests -> i_resp=d_resp=0, state stays IDLE.

Source files
------------

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one pmem cacheline port between I$ and D$.
// Ports: i_* / d_* requester sides, pmem_* lower level, clk, rst (async low).
module cacheline_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              last_d_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic i_req;
  logic d_req;
  logic pick_i;
  logic pick_d;
  logic busy;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // D wins a tie unless it was the last side served.
  assign pick_d = (state_q == IDLE) & d_req
                & (~i_req | ~last_d_q);
  assign pick_i = (state_q == IDLE) & i_req & ~pick_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_d:  state_d = BUSY_D;
          pick_i:  state_d = BUSY_I;
          default: state_d = IDLE;
        endcase
      end
      BUSY_I, BUSY_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pick_d) begin
        last_d_q <= 1'b1;
        wr_q     <= d_write;
        addr_q   <= d_addr;
        wdata_q  <= d_wdata;
      end else if (pick_i) begin
        last_d_q <= 1'b0;
        wr_q     <= 1'b0;
        addr_q   <= i_addr;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign pmem_read  = busy & ~wr_q;
  assign pmem_write = busy & wr_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;

  assign i_resp  = (state_q == BUSY_I) & pmem_resp;
  assign d_resp  = (state_q == BUSY_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed self-checking bench for cacheline_arbiter.
// Drives inputs 1ns after the rising edge and samples combinational results.
module tb_cacheline_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int n_chk;
  int n_pass;

  localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_12 = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] PAT_3C = {32{8'h3C}};

  cacheline_arbiter #(
    .LINE_W(LINE_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .pmem_read (pmem_read),
    .pmem_write(pmem_write),
    .pmem_addr (pmem_addr),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [LINE_W-1:0] got,
                     input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    rst        = 1'b0;
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // reset state
    #12;
    chk("rst_rd", pmem_read, 0);
    chk("rst_wr", pmem_write, 0);
    chk("rst_addr", pmem_addr, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_iresp", i_resp, 0);
    chk("rst_dresp", d_resp, 0);
    step();
    rst = 1'b1;

    // D-only read, pmem_resp in cycle 3
    d_read = 1'b1;
    d_addr = 32'h0000_1000;
    step();
    chk("t1_rd_c1", pmem_read, 1);
    chk("t1_wr_c1", pmem_write, 0);
    chk("t1_addr", pmem_addr, 32'h1000);
    chk("t1_dresp_c1", d_resp, 0);
    step();
    chk("t1_rd_c2", pmem_read, 1);
    step();
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_A5;
    #1;
    chk("t1_rd_c3", pmem_read, 1);
    chk("t1_dresp_c3", d_resp, 1);
    chk("t1_drdata", d_rdata, PAT_A5);
    chk("t1_iresp_c3", i_resp, 0);
    d_read = 1'b0;
    step();
    pmem_resp = 1'b0;
    #1;
    chk("t1_rd_c4", pmem_read, 0);
    chk("t1_dresp_c4", d_resp, 0);

    // tie straight after reset: D write first, then I read
    do_reset();
    i_read  = 1'b1;
    i_addr  = 32'h40;
    d_write = 1'b1;
    d_addr  = 32'h80;
    d_wdata = PAT_12;
    step();
    chk("t2_d_wr", pmem_write, 1);
    chk("t2_d_rd", pmem_read, 0);
    chk("t2_d_addr", pmem_addr, 32'h80);
    chk("t2_d_wdata", pmem_wdata, PAT_12);
    pmem_resp = 1'b1;
    #1;
    chk("t2_dresp", d_resp, 1);
    chk("t2_iresp0", i_resp, 0);
    d_write = 1'b0;
    step();
    pmem_resp = 1'b0;
    #1;
    chk("t2_gap_rd", pmem_read, 0);
    chk("t2_gap_wr", pmem_write, 0);
    step();
    chk("t2_i_rd", pmem_read, 1);
    chk("t2_i_wr", pmem_write, 0);
    chk("t2_i_addr", pmem_addr, 32'h40);
    pmem_resp = 1'b1;
    #1;
    chk("t2_iresp", i_resp, 1);
    chk("t2_dresp0", d_resp, 0);
    i_read = 1'b0;
    step();
    pmem_resp = 1'b0;

    // both held: grants alternate D,I,D,I,D,I
    i_read = 1'b1;
    i_addr = 32'h400;
    d_read = 1'b1;
    d_addr = 32'h800;
    for (int k = 0; k < 6; k++) begin
      bit seen;
      seen = 1'b0;
      for (int w = 0; w < 8 && !seen; w++) begin
        step();
        pmem_resp = 1'b0;
        #1;
        if (pmem_read || pmem_write) seen = 1'b1;
      end
      if (!seen) chk("t3_timeout", 0, 1);
      else begin
        chk("t3_order", pmem_addr,
            (k % 2 == 0) ? 32'h800 : 32'h400);
        chk("t3_excl", pmem_read & pmem_write, 0);
        pmem_resp = 1'b1;
        #1;
        chk("t3_iresp", i_resp, (k % 2 == 1) ? 1 : 0);
        chk("t3_dresp", d_resp, (k % 2 == 0) ? 1 : 0);
      end
    end
    i_read = 1'b0;
    d_read = 1'b0;
    step();
    pmem_resp = 1'b0;

    // requester inputs ignored while busy
    i_read = 1'b1;
    i_addr = 32'h100;
    step();
    chk("t4_i_rd", pmem_read, 1);
    i_addr = 32'h200;
    d_read = 1'b1;
    d_addr = 32'h300;
    step();
    chk("t4_addr_hold1", pmem_addr, 32'h100);
    step();
    chk("t4_addr_hold2", pmem_addr, 32'h100);
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_3C;
    #1;
    chk("t4_iresp", i_resp, 1);
    chk("t4_irdata", i_rdata, PAT_3C);
    chk("t4_dresp0", d_resp, 0);
    i_read = 1'b0;
    step();
    pmem_resp = 1'b0;
    #1;
    chk("t4_gap", pmem_read, 0);
    step();
    chk("t4_d_rd", pmem_read, 1);
    chk("t4_d_addr", pmem_addr, 32'h300);
    pmem_resp = 1'b1;
    #1;
    chk("t4_dresp", d_resp, 1);
    d_read = 1'b0;
    step();
    pmem_resp = 1'b0;

    // async reset mid-transaction
    d_write = 1'b1;
    d_addr  = 32'h500;
    d_wdata = PAT_12;
    step();
    chk("t5_wr", pmem_write, 1);
    step();
    #2;
    rst       = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk("t5_rst_wr", pmem_write, 0);
    chk("t5_rst_rd", pmem_read, 0);
    chk("t5_rst_addr", pmem_addr, 0);
    chk("t5_rst_wdata", pmem_wdata, 0);
    chk("t5_rst_dresp", d_resp, 0);
    pmem_resp = 1'b0;
    d_write   = 1'b0;
    step();
    rst    = 1'b1;
    i_read = 1'b1;
    i_addr = 32'h600;
    d_read = 1'b1;
    d_addr = 32'h700;
    step();
    chk("t5_tie_addr", pmem_addr, 32'h700);
    chk("t5_tie_rd", pmem_read, 1);
    pmem_resp = 1'b1;
    #1;
    chk("t5_dresp", d_resp, 1);
    i_read = 1'b0;
    d_read = 1'b0;
    step();
    pmem_resp = 1'b0;

    // stray pmem_resp while idle
    step();
    pmem_resp = 1'b1;
    #1;
    chk("t6_iresp", i_resp, 0);
    chk("t6_dresp", d_resp, 0);
    step();
    pmem_resp = 1'b0;
    #1;
    chk("t6_rd", pmem_read, 0);
    chk("t6_wr", pmem_write, 0);
    i_read = 1'b1;
    i_addr = 32'h900;
    step();
    chk("t6_next_rd", pmem_read, 1);
    chk("t6_next_addr", pmem_addr, 32'h900);
    i_read = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
